fetch_mem_arbiter: RTL and testbench

- Shares one pipelined single-port synchronous SRAM between the instruction-fetch requester and the data (load/store) requester.
- Both requesters use an sram-like split handshake: req/addr_ok for the address phase, data_ok for the response phase.
- Data requests have fixed priority. A starvation counter guarantees fetch progress.
- Tags each issued access and routes the returned read data and data_ok back to its owner after the fixed memory latency.

---
 rtl/fetch_mem_arbiter.sv | 112 +++++++++++
 tb/tb_fetch_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_mem_arbiter.sv
// Arbitrates one pipelined single-port SRAM between instruction fetch and data
// requesters, tagging each access so its response returns to its owner.
module fetch_mem_arbiter #(
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
    $error("fetch_mem_arbiter: MEM_LAT must be in 1..4");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("fetch_mem_arbiter: STARVE_LIMIT must be in 1..15");
  end

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_DATA,
    GNT_INST
  } grant_e;

  typedef struct packed {
    logic valid;
    logic is_inst;
  } tag_t;

  grant_e     grant;
  logic [3:0] starve_cnt;
  tag_t       tags [MEM_LAT];
  tag_t       tag_out;

  // Data normally wins contention; a fetch that has lost STARVE_LIMIT times
  // in a row takes the next contended cycle.
  always_comb begin
    // NOTE: default first so every path assigns grant and no latch is inferred.
    grant = GNT_NONE;
    if (resetn) begin
      if (data_req && !(inst_req && starve_cnt == STARVE_MAX)) begin
        grant = GNT_DATA;
      end else if (inst_req) begin
        grant = GNT_INST;
      end
    end
  end

  always_comb begin
    inst_addr_ok = (grant == GNT_INST);
    data_addr_ok = (grant == GNT_DATA);
    mem_en       = (grant != GNT_NONE);
    mem_we       = (grant == GNT_DATA && data_wr) ? data_wstrb : 4'b0000;
    mem_addr     = (grant == GNT_INST) ? inst_addr : data_addr;
    mem_wdata    = data_wdata;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (!resetn) begin
      starve_cnt <= 4'd0;
    end else if (!inst_req || grant == GNT_INST) begin
      starve_cnt <= 4'd0;
    end else if (grant == GNT_DATA && starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Tag shift register mirrors the SRAM read pipeline: the last stage lines up
  // with the cycle mem_rdata for that access is valid.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      // NOTE: the tag stages are reset (unlike a data RAM) because stale valid
      // bits would fabricate responses after reset.
      for (int i = 0; i < MEM_LAT; i++) begin
        tags[i] <= '0;
      end
    end else begin
      tags[0] <= '{valid: mem_en, is_inst: (grant == GNT_INST)};
      for (int i = 1; i < MEM_LAT; i++) begin
        tags[i] <= tags[i-1];
      end
    end
  end

  assign tag_out      = tags[MEM_LAT-1];
  assign inst_data_ok = resetn && tag_out.valid && tag_out.is_inst;
  assign data_data_ok = resetn && tag_out.valid && !tag_out.is_inst;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Bench for fetch_mem_arbiter: MEM_LAT=1 and MEM_LAT=3 instances share stimulus;
// a due-cycle response schedule and a fetch-loss counter give expected values.
module tb_fetch_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, data_req, data_wr;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [3:0]  data_wstrb;

  logic        iaok [2];
  logic        idok [2];
  logic [31:0] irdata [2];
  logic        daok [2];
  logic        ddok [2];
  logic [31:0] drdata [2];
  logic        men [2];
  logic [3:0]  mwe [2];
  logic [31:0] maddr [2];
  logic [31:0] mwdata [2];
  logic [31:0] mrdata [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fetch_mem_arbiter #(.MEM_LAT(1), .STARVE_LIMIT(LIMIT)) dut1 (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(iaok[0]),
    .inst_data_ok(idok[0]), .inst_rdata(irdata[0]),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(daok[0]),
    .data_data_ok(ddok[0]), .data_rdata(drdata[0]),
    .mem_en(men[0]), .mem_we(mwe[0]), .mem_addr(maddr[0]),
    .mem_wdata(mwdata[0]), .mem_rdata(mrdata[0])
  );

  fetch_mem_arbiter #(.MEM_LAT(3), .STARVE_LIMIT(LIMIT)) dut3 (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(iaok[1]),
    .inst_data_ok(idok[1]), .inst_rdata(irdata[1]),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(daok[1]),
    .data_data_ok(ddok[1]), .data_rdata(drdata[1]),
    .mem_en(men[1]), .mem_we(mwe[1]), .mem_addr(maddr[1]),
    .mem_wdata(mwdata[1]), .mem_rdata(mrdata[1])
  );

  // Read data content is a fixed function of the address, so each response
  // can be tied to the exact access that produced it.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h3c5a_96e1;
  endfunction

  // Memory stand-ins: a delay line of issued addresses per latency.
  logic [32:0] p1;
  logic [32:0] p3 [3];
  always @(posedge clk) begin
    p1    <= {men[0], maddr[0]};
    p3[0] <= {men[1], maddr[1]};
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mrdata[0] = p1[32]    ? mem_fn(p1[31:0])    : 32'hbad0_bad0;
  assign mrdata[1] = p3[2][32] ? mem_fn(p3[2][31:0]) : 32'hbad0_bad0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          v;
    bit          is_inst;
    bit          wr;
    logic [31:0] addr;
  } resp_t;

  resp_t sched [2][8];
  int    m_starve = 0;

  task automatic check_quiet(input bit k);
    check($sformatf("d%0d rst iaok", k), 32'(iaok[k]), 0);
    check($sformatf("d%0d rst daok", k), 32'(daok[k]), 0);
    check($sformatf("d%0d rst idok", k), 32'(idok[k]), 0);
    check($sformatf("d%0d rst ddok", k), 32'(ddok[k]), 0);
    check($sformatf("d%0d rst men", k), 32'(men[k]), 0);
    check($sformatf("d%0d rst mwe", k), 32'(mwe[k]), 0);
  endtask

  task automatic model_dut(input bit k, input bit g_inst, input bit g_data);
    int          lat;
    logic [2:0]  s_now, s_due;
    resp_t       r;
    lat = k ? 3 : 1;
    s_now = 3'(cyc);
    s_due = 3'(cyc + lat);
    check($sformatf("d%0d iaok", k), 32'(iaok[k]), 32'(g_inst));
    check($sformatf("d%0d daok", k), 32'(daok[k]), 32'(g_data));
    check($sformatf("d%0d men", k), 32'(men[k]), 32'(g_inst | g_data));
    check($sformatf("d%0d mwe", k), 32'(mwe[k]), (g_data && data_wr) ? 32'(data_wstrb) : 0);
    if (g_inst) check($sformatf("d%0d maddr", k), maddr[k], inst_addr);
    if (g_data) check($sformatf("d%0d maddr", k), maddr[k], data_addr);
    if (g_data && data_wr) check($sformatf("d%0d mwdata", k), mwdata[k], data_wdata);
    r = sched[k][s_now];
    sched[k][s_now].v = 1'b0;
    check($sformatf("d%0d idok", k), 32'(idok[k]), 32'(r.v && r.is_inst));
    check($sformatf("d%0d ddok", k), 32'(ddok[k]), 32'(r.v && !r.is_inst));
    if (r.v && r.is_inst) check($sformatf("d%0d irdata", k), irdata[k], mem_fn(r.addr));
    if (r.v && !r.is_inst && !r.wr) check($sformatf("d%0d drdata", k), drdata[k], mem_fn(r.addr));
    if (g_inst || g_data)
      sched[k][s_due] = '{v: 1'b1, is_inst: g_inst, wr: g_data && data_wr,
                          addr: g_inst ? inst_addr : data_addr};
  endtask

  task automatic model_step();
    bit fetch_wins, g_inst, g_data;
    if (!resetn) begin
      for (int k = 0; k < 2; k++)
        for (int s = 0; s < 8; s++) sched[k][s].v = 1'b0;
      m_starve = 0;
      check_quiet(1'b0);
      check_quiet(1'b1);
      return;
    end
    if (inst_req && data_req) fetch_wins = (m_starve >= LIMIT);
    else                      fetch_wins = inst_req;
    g_inst = fetch_wins;
    g_data = data_req && !fetch_wins;
    model_dut(1'b0, g_inst, g_data);
    model_dut(1'b1, g_inst, g_data);
    if (inst_req && g_data) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
    else                    m_starve = 0;
  endtask

  always @(negedge clk) model_step();

  // ---------------- stimulus ----------------
  task automatic drive(input bit rn, input bit ir, input logic [31:0] ia,
                       input bit dr, input bit dw, input logic [3:0] ds,
                       input logic [31:0] da, input logic [31:0] dd);
    @(posedge clk);
    #1;
    resetn = rn; inst_req = ir; inst_addr = ia;
    data_req = dr; data_wr = dw; data_wstrb = ds; data_addr = da; data_wdata = dd;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  typedef struct {
    bit         ireq, dreq, dwr;
    logic [3:0] strb;
    bit         e_iaok, e_daok, e_en;
    logic [3:0] e_we;
  } vec_t;

  vec_t vecs [14];

  initial begin
    bit e_daok [7] = '{1, 1, 1, 1, 0, 1, 0};
    bit e_iaok [7] = '{0, 0, 0, 0, 1, 0, 0};
    bit e_ddok [7] = '{0, 1, 1, 1, 1, 0, 1};
    bit e_idok [7] = '{0, 0, 0, 0, 0, 1, 0};
    bit m_idok [6] = '{0, 0, 0, 1, 0, 1};
    bit m_ddok [6] = '{0, 0, 0, 0, 1, 0};

    // ireq dreq dwr strb | iaok daok en we   (starvation count tracked by hand)
    vecs[0]  = '{0, 0, 0, 4'h0, 0, 0, 0, 4'h0};
    vecs[1]  = '{1, 0, 0, 4'h0, 1, 0, 1, 4'h0};
    vecs[2]  = '{0, 1, 0, 4'hf, 0, 1, 1, 4'h0};
    vecs[3]  = '{0, 1, 1, 4'ha, 0, 1, 1, 4'ha};
    vecs[4]  = '{1, 1, 0, 4'h0, 0, 1, 1, 4'h0};
    vecs[5]  = '{1, 1, 0, 4'h0, 0, 1, 1, 4'h0};
    vecs[6]  = '{1, 1, 0, 4'h0, 0, 1, 1, 4'h0};
    vecs[7]  = '{1, 1, 0, 4'h0, 0, 1, 1, 4'h0};
    vecs[8]  = '{1, 1, 1, 4'h5, 1, 0, 1, 4'h0};
    vecs[9]  = '{1, 1, 1, 4'hf, 0, 1, 1, 4'hf};
    vecs[10] = '{1, 0, 0, 4'h0, 1, 0, 1, 4'h0};
    vecs[11] = '{1, 1, 0, 4'h0, 0, 1, 1, 4'h0};
    vecs[12] = '{0, 0, 0, 4'h0, 0, 0, 0, 4'h0};
    vecs[13] = '{1, 1, 0, 4'h0, 0, 1, 1, 4'h0};

    resetn = 1'b0; inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b1;
    data_wstrb = 4'hf; inst_addr = 32'h1c00_0000; data_addr = 32'h10;
    data_wdata = 32'h1234_5678;
    repeat (3) @(negedge clk);
    check_quiet(1'b0);
    check_quiet(1'b1);

    // Idle: nothing issued, nothing returned.
    for (int c = 0; c < 10; c++) begin
      idle();
      check("idle men1", 32'(men[0]), 0);
      check("idle men3", 32'(men[1]), 0);
      check("idle ok", 32'({iaok[0], daok[0], idok[0], ddok[0], iaok[1], daok[1], idok[1], ddok[1]}), 0);
      check("idle mwe", 32'({mwe[0], mwe[1]}), 0);
    end

    // Arbitration table.
    for (int i = 0; i < 14; i++) begin
      logic [31:0] ia, da;
      ia = 32'h1c00_0000 + 32'(i * 4);
      da = 32'h0000_1000 + 32'(i * 4);
      drive(1'b1, vecs[i].ireq, ia, vecs[i].dreq, vecs[i].dwr, vecs[i].strb, da, 32'ha500_0000 | 32'(i));
      for (int k = 0; k < 2; k++) begin
        check($sformatf("vec%0d iaok", i), 32'(iaok[k]), 32'(vecs[i].e_iaok));
        check($sformatf("vec%0d daok", i), 32'(daok[k]), 32'(vecs[i].e_daok));
        check($sformatf("vec%0d men", i), 32'(men[k]), 32'(vecs[i].e_en));
        check($sformatf("vec%0d mwe", i), 32'(mwe[k]), 32'(vecs[i].e_we));
        if (vecs[i].e_en) check($sformatf("vec%0d maddr", i), maddr[k], vecs[i].e_iaok ? ia : da);
      end
    end
    repeat (4) idle();

    // Single fetch, MEM_LAT=1.
    drive(1'b1, 1'b1, 32'h1c00_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("fetch iaok", 32'(iaok[0]), 1);
    check("fetch men", 32'(men[0]), 1);
    check("fetch mwe", 32'(mwe[0]), 0);
    check("fetch maddr", maddr[0], 32'h1c00_0000);
    idle();
    check("fetch idok", 32'(idok[0]), 1);
    check("fetch irdata", irdata[0], mem_fn(32'h1c00_0000));
    check("fetch ddok", 32'(ddok[0]), 0);
    repeat (2) idle();

    // Contention with starvation escape, MEM_LAT=1.
    for (int c = 0; c < 7; c++) begin
      bit r;
      r = (c <= 5);
      drive(1'b1, r, 32'h1c00_0100, r, 1'b0, 4'h0, 32'h0000_1000, 32'h0);
      check($sformatf("cont%0d daok", c), 32'(daok[0]), 32'(e_daok[c]));
      check($sformatf("cont%0d iaok", c), 32'(iaok[0]), 32'(e_iaok[c]));
      check($sformatf("cont%0d ddok", c), 32'(ddok[0]), 32'(e_ddok[c]));
      check($sformatf("cont%0d idok", c), 32'(idok[0]), 32'(e_idok[c]));
      if (e_ddok[c]) check($sformatf("cont%0d drdata", c), drdata[0], mem_fn(32'h0000_1000));
    end
    repeat (2) idle();

    // Byte-strobed write, MEM_LAT=1.
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h8, 32'hdead_beef);
    check("wr mwe", 32'(mwe[0]), 32'h3);
    check("wr mwdata", mwdata[0], 32'hdead_beef);
    check("wr maddr", maddr[0], 32'h8);
    check("wr daok", 32'(daok[0]), 1);
    idle();
    check("wr ddok", 32'(ddok[0]), 1);
    check("wr idok", 32'(idok[0]), 0);
    repeat (4) idle();

    // Mixed traffic, MEM_LAT=3.
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: drive(1'b1, 1'b1, 32'h1c00_0040, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        1: drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0000_2000, 32'h0);
        2: drive(1'b1, 1'b1, 32'h1c00_0080, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        default: idle();
      endcase
      check($sformatf("mix%0d idok", c), 32'(idok[1]), 32'(m_idok[c]));
      check($sformatf("mix%0d ddok", c), 32'(ddok[1]), 32'(m_ddok[c]));
      if (c == 3) check("mix irdata A", irdata[1], mem_fn(32'h1c00_0040));
      if (c == 4) check("mix drdata", drdata[1], mem_fn(32'h0000_2000));
      if (c == 5) check("mix irdata B", irdata[1], mem_fn(32'h1c00_0080));
    end
    repeat (4) idle();

    // Reset while an access is in flight, MEM_LAT=3.
    drive(1'b1, 1'b1, 32'h1c00_00c0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("rmf iaok", 32'(iaok[1]), 1);
    drive(1'b0, 1'b1, 32'h1c00_00c4, 1'b1, 1'b1, 4'hf, 32'h40, 32'h0);
    check_quiet(1'b0);
    check_quiet(1'b1);
    idle();
    check("rmf T+2 ok", 32'({idok[1], ddok[1]}), 0);
    idle();
    check("rmf T+3 idok", 32'(idok[1]), 0);
    check("rmf T+3 ddok", 32'(ddok[1]), 0);
    repeat (4) idle();

    // Random traffic against the model, with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 199) != 0,
            $urandom_range(0, 99) < 65, $urandom(),
            $urandom_range(0, 99) < 65, 1'($urandom_range(0, 1)), 4'($urandom()),
            $urandom(), $urandom());
    end
    repeat (5) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
